// File: rtl/seq_pattern_gen_if.sv
// seq_pattern_gen_if: request/serial-output bundle for the serial pattern generator.
// The master side requests patterns and watches the serial line; the slave side is the generator.
interface seq_pattern_gen_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic             hold;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output start, pattern, len, hold,
        input  sout, sout_valid, busy, done, state
    );

    modport slave (
        input  start, pattern, len, hold,
        output sout, sout_valid, busy, done, state
    );
endinterface

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: sends one pattern MSB-first on a serial line, with hold stall and a done pulse.
// Optional macro SEQ_PATTERN_GEN_LOOP_EN: start in DONE reloads and shifts again without an IDLE gap.
module seq_pattern_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    seq_pattern_gen_if.slave bus
);
    localparam int unsigned LEN_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_DONE  = 3'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [LEN_W-1:0] r_remain;
    logic [LEN_W-1:0] w_remain_nxt;
    logic [LEN_W-1:0] w_eff_len;
    logic [WIDTH-1:0] w_load_word;
    logic             r_sout;
    logic             r_sout_valid;
    logic             r_busy;
    logic             r_done;
    logic             w_sout_nxt;
    logic             w_sout_valid_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Effective length and the MSB-aligned load word: bit len-1 lands in the top bit.
    always_comb begin
        if ((bus.len == '0) || (32'(bus.len) > WIDTH)) begin
            w_eff_len = LEN_W'(WIDTH);
        end else begin
            w_eff_len = bus.len;
        end
        w_load_word = bus.pattern << (LEN_W'(WIDTH) - w_eff_len);
    end

    // Next-state, datapath and next-output decode.
    always_comb begin
        w_state_nxt  = r_state;
        w_shift_nxt  = r_shift;
        w_remain_nxt = r_remain;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt  = ST_SHIFT;
                    w_shift_nxt  = w_load_word;
                    w_remain_nxt = w_eff_len;
                end
            end
            ST_SHIFT: begin
                if (!bus.hold) begin
                    if (r_remain <= LEN_W'(1)) begin
                        w_state_nxt  = ST_DONE;
                        w_shift_nxt  = '0;
                        w_remain_nxt = '0;
                    end else begin
                        w_shift_nxt  = r_shift << 1;
                        w_remain_nxt = r_remain - LEN_W'(1);
                    end
                end
            end
            ST_DONE: begin
`ifdef SEQ_PATTERN_GEN_LOOP_EN
                if (bus.start) begin
                    w_state_nxt  = ST_SHIFT;
                    w_shift_nxt  = w_load_word;
                    w_remain_nxt = w_eff_len;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_shift_nxt  = '0;
                w_remain_nxt = '0;
            end
        endcase

        // Outputs are a pure decode of the upcoming registered state and shift word.
        w_sout_valid_nxt = (w_state_nxt == ST_SHIFT);
        w_busy_nxt       = (w_state_nxt == ST_SHIFT) || (w_state_nxt == ST_DONE);
        w_done_nxt       = (w_state_nxt == ST_DONE);
        w_sout_nxt       = (w_state_nxt == ST_SHIFT) ? w_shift_nxt[WIDTH-1] : IDLE_LEVEL;
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_remain     <= '0;
            r_sout       <= IDLE_LEVEL;
            r_sout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_remain     <= w_remain_nxt;
            r_sout       <= w_sout_nxt;
            r_sout_valid <= w_sout_valid_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
        end
    end

    assign bus.sout       = r_sout;
    assign bus.sout_valid = r_sout_valid;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: self-checking bench for seq_pattern_gen against a bit-index reference model.
module tb_seq_pattern_gen;
    localparam int unsigned WIDTH      = 8;
    localparam bit          IDLE_LEVEL = 1'b1;
    localparam int unsigned LEN_W      = $clog2(WIDTH + 1);

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seq_pattern_gen_if #(.WIDTH(WIDTH)) bus ();

    seq_pattern_gen #(
        .WIDTH      (WIDTH),
        .IDLE_LEVEL (IDLE_LEVEL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic int unsigned eff_len(input logic [LEN_W-1:0] l);
        int unsigned lv;
        lv = 32'(l);
        if (lv == 0 || lv > WIDTH) return WIDTH;
        return lv;
    endfunction

    // Sends one word from IDLE and checks every cycle until the IDLE cycle after DONE.
    task automatic run_word(input logic [WIDTH-1:0] pat, input logic [LEN_W-1:0] ln,
                            input logic [31:0] hold_mask, input bit noise, input string tag,
                            output int unsigned busy_cycles, output logic [31:0] stream);
        int unsigned eff, idx, cyc;
        logic        h, exp_bit;
        logic [6:0]  act, expv;
        eff = eff_len(ln);
        idx = 0;
        cyc = 0;
        busy_cycles = 0;
        stream = '0;
        bus.pattern = pat;
        bus.len     = ln;
        bus.hold    = 1'b0;
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (idx < eff) begin
            exp_bit = pat[eff-1-idx];
            if (bus.busy) busy_cycles++;
            act  = {bus.state, bus.sout, bus.sout_valid, bus.busy, bus.done};
            expv = {3'd1, exp_bit, 1'b1, 1'b1, 1'b0};
            n_checks++;
            if (act !== expv) begin
                n_fail++;
                $display("FAIL %s shift cyc %0d bit %0d: {state,sout,valid,busy,done} got %b want %b",
                         tag, cyc, idx, act, expv);
            end
            h = (cyc < 32) ? hold_mask[cyc] : 1'b0;
            bus.hold = h;
            if (noise) begin
                bus.start   = 1'($urandom);
                bus.pattern = WIDTH'($urandom);
                bus.len     = LEN_W'($urandom);
            end
            if (!h) begin
                stream = {stream[30:0], bus.sout};
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.hold  = 1'($urandom);
        if (bus.busy) busy_cycles++;
        act  = {bus.state, bus.sout, bus.sout_valid, bus.busy, bus.done};
        expv = {3'd2, IDLE_LEVEL, 1'b0, 1'b1, 1'b1};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s done cycle: got %b want %b", tag, act, expv);
        end
        @(negedge clk);
        bus.hold = 1'b0;
        act  = {bus.state, bus.sout, bus.sout_valid, bus.busy, bus.done};
        expv = {3'd0, IDLE_LEVEL, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s idle after done: got %b want %b", tag, act, expv);
        end
    endtask

    task automatic test_reset();
        logic [6:0] act, expv;
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.hold  = 1'b1;
        repeat (3) @(negedge clk);
        act  = {bus.state, bus.sout, bus.sout_valid, bus.busy, bus.done};
        expv = {3'd0, IDLE_LEVEL, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", act, expv);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
    endtask

    task automatic test_directed();
        int unsigned b;
        logic [31:0] s;
        run_word(8'b1011_0010, LEN_W'(8), 32'h0, 1'b0, "directed_b2", b, s);
        n_checks++;
        if (s[7:0] !== 8'b1011_0010 || b != 9) begin
            n_fail++;
            $display("FAIL directed_b2 stream/busy: got %b/%0d want 10110010/9", s[7:0], b);
        end
    endtask

    task automatic test_len_boundary();
        int unsigned b;
        logic [31:0] s;
        run_word(8'hFF, LEN_W'(0), 32'h0, 1'b0, "len0", b, s);
        n_checks++;
        if (s[7:0] !== 8'hFF || b != 9) begin
            n_fail++;
            $display("FAIL len0 stream/busy: got %h/%0d want ff/9", s[7:0], b);
        end
        run_word(8'b0000_0101, LEN_W'(3), 32'h0, 1'b0, "len3", b, s);
        n_checks++;
        if (s[3:0] !== 4'b0101 || b != 4) begin
            n_fail++;
            $display("FAIL len3 stream/busy: got %b/%0d want 0101/4", s[3:0], b);
        end
        run_word(8'h3C, LEN_W'(15), 32'h0, 1'b0, "len15", b, s);
        n_checks++;
        if (s[7:0] !== 8'h3C || b != 9) begin
            n_fail++;
            $display("FAIL len15 stream/busy: got %h/%0d want 3c/9", s[7:0], b);
        end
    endtask

    task automatic test_hold();
        int unsigned b;
        logic [31:0] s;
        run_word(8'hA5, LEN_W'(8), 32'h0000_000E, 1'b0, "hold_a5", b, s);
        n_checks++;
        if (s[7:0] !== 8'hA5 || b != 12) begin
            n_fail++;
            $display("FAIL hold_a5 stream/busy: got %h/%0d want a5/12", s[7:0], b);
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] act, expv;
        bus.pattern = 8'hA5;
        bus.len     = LEN_W'(8);
        bus.start   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus.state, bus.sout} !== {3'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid 5th bit: got %b want 0010", {bus.state, bus.sout});
        end
        reset     = 1'b1;
        bus.start = 1'b1;
        bus.hold  = 1'b1;
        @(negedge clk);
        act  = {bus.state, bus.sout, bus.sout_valid, bus.busy, bus.done};
        expv = {3'd0, IDLE_LEVEL, 1'b0, 1'b0, 1'b0};
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL reset_mid abort: got %b want %b", act, expv);
        end
        reset     = 1'b0;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.state !== 3'd0) begin
                n_fail++;
                $display("FAIL reset_mid no_done k=%0d: done %b state %0d want 0/0", k, bus.done, bus.state);
            end
        end
    endtask

    task automatic test_start_held();
        logic [2:0] exp_st [9];
        logic       exp_so [9];
        bit         idle_seen;
`ifdef SEQ_PATTERN_GEN_LOOP_EN
        exp_st = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd1, 3'd1, 3'd1, 3'd2, 3'd1};
        exp_so = '{1'b1, 1'b0, 1'b1, IDLE_LEVEL, 1'b1, 1'b0, 1'b1, IDLE_LEVEL, 1'b1};
`else
        exp_st = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2};
        exp_so = '{1'b1, 1'b0, 1'b1, IDLE_LEVEL, IDLE_LEVEL, 1'b1, 1'b0, 1'b1, IDLE_LEVEL};
`endif
        bus.pattern = 8'b0000_0101;
        bus.len     = LEN_W'(3);
        bus.hold    = 1'b0;
        bus.start   = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.state !== exp_st[k] || bus.sout !== exp_so[k]) begin
                n_fail++;
                $display("FAIL start_held k=%0d: state/sout got %0d/%b want %0d/%b",
                         k, bus.state, bus.sout, exp_st[k], exp_so[k]);
            end
        end
        bus.start = 1'b0;
        idle_seen = 1'b0;
        for (int k = 0; k < 8 && !idle_seen; k++) begin
            @(negedge clk);
            if (bus.state === 3'd0 && bus.busy === 1'b0) idle_seen = 1'b1;
        end
        n_checks++;
        if (!idle_seen) begin
            n_fail++;
            $display("FAIL start_held drain: got state %0d want 0 within 8 cycles", bus.state);
        end
    endtask

    task automatic test_detector_stream();
        int unsigned b, hits;
        logic [31:0] s;
        logic [7:0]  w;
        run_word(8'b1011_0110, LEN_W'(8), 32'h0, 1'b0, "detector_b6", b, s);
        w = s[7:0];
        hits = 0;
        for (int p = 7; p >= 3; p--) begin
            if (w[p -: 4] == 4'b1011) hits++;
        end
        n_checks++;
        if (w !== 8'b1011_0110 || hits != 2) begin
            n_fail++;
            $display("FAIL detector_b6 stream/hits: got %b/%0d want 10110110/2", w, hits);
        end
    endtask

    task automatic test_random();
        int unsigned b, gap;
        logic [31:0] s;
        logic [WIDTH-1:0] pat;
        logic [LEN_W-1:0] ln;
        int unsigned eff;
        logic [31:0] mask_eff;
        for (int n = 0; n < 40; n++) begin
            pat = WIDTH'($urandom);
            ln  = LEN_W'($urandom_range(0, 15));
            run_word(pat, ln, $urandom & $urandom, 1'b1, "random", b, s);
            eff = eff_len(ln);
            mask_eff = (32'd1 << eff) - 32'd1;
            n_checks++;
            if ((s & mask_eff) !== (32'(pat) & mask_eff)) begin
                n_fail++;
                $display("FAIL random word %0d stream: got %h want %h (len %0d)",
                         n, s & mask_eff, 32'(pat) & mask_eff, ln);
            end
            gap = $urandom_range(0, 2);
            for (int g = 0; g < int'(gap); g++) begin
                bus.hold = 1'($urandom);
                @(negedge clk);
                n_checks++;
                if (bus.state !== 3'd0 || bus.sout_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL random idle gap: state/valid got %0d/%b want 0/0",
                             bus.state, bus.sout_valid);
                end
            end
            bus.hold = 1'b0;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.pattern = '0;
        bus.len     = '0;
        bus.hold    = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_len_boundary();
        test_hold();
        test_reset_mid();
        test_start_held();
        test_detector_stream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
